// File: rtl/spi_adc_reader.sv
// ============================================================================
//  Module   : spi_adc_reader
//  Purpose  : SPI master that reads one SAMPLE_WIDTH-bit word per frame from
//             the microphone ADC and hands it out on a valid/ready stream.
//             Define SPI_ADC_READER_OVERRUN_COUNT_EN for a saturating overrun
//             counter (overrun_count / overrun_clear).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_adc_reader #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int HALF_PERIOD    = 2,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    enable,
  output logic                    spi_clock,
  output logic                    spi_chipselect,
  input  logic                    spi_data,
  output logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun,
`ifdef SPI_ADC_READER_OVERRUN_COUNT_EN
  output logic [15:0]             overrun_count,
  input  logic                    overrun_clear,
`endif
  output logic                    busy
);

  localparam int c_cnt_max = (HALF_PERIOD > CS_HIGH_CYCLES) ? HALF_PERIOD : CS_HIGH_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam int c_bit_w   = $clog2(SAMPLE_WIDTH + 1);

  localparam logic [c_cnt_w-1:0] c_hp_last = c_cnt_w'(HALF_PERIOD - 1);
  localparam logic [c_cnt_w-1:0] c_cs_last = c_cnt_w'(CS_HIGH_CYCLES - 1);
  localparam logic [c_bit_w-1:0] c_bits    = c_bit_w'(SAMPLE_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [c_cnt_w-1:0]        r_cnt;
  logic [c_bit_w-1:0]        r_bit_cnt;
  logic [SAMPLE_WIDTH-1:0]   r_shift;
  logic                      r_sclk;
  logic                      r_cs;
  logic [SAMPLE_WIDTH-1:0]   r_data;
  logic                      r_valid;
  logic                      r_overrun;
  logic                      w_phase_end;
  logic                      w_enter_high;

  assign w_phase_end  = (r_cnt == c_hp_last);
  assign w_enter_high = (r_state == ST_LOW) && (w_next_state == ST_HIGH);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (enable && (r_cnt == c_cs_last)) w_next_state = ST_SETUP;
      ST_SETUP: if (w_phase_end) w_next_state = ST_LOW;
      ST_LOW:   if (w_phase_end) w_next_state = ST_HIGH;
      ST_HIGH:  if (w_phase_end) w_next_state = (r_bit_cnt == c_bits) ? ST_DONE : ST_LOW;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Phase counter restarts on every state change; in IDLE it only counts enabled clocks.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (w_next_state != r_state) begin
      r_cnt <= '0;
    end else if ((r_state == ST_IDLE) && !enable) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (r_state == ST_IDLE) begin
      r_bit_cnt <= '0;
    end else if (w_enter_high) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
      r_shift   <= {r_shift[SAMPLE_WIDTH-2:0], spi_data};
    end
  end

  // SPI pins are registered from the next state so they change cleanly on one edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sclk <= 1'b1;
      r_cs   <= 1'b1;
    end else begin
      r_sclk <= (w_next_state != ST_LOW);
      r_cs   <= (w_next_state == ST_IDLE) || (w_next_state == ST_DONE);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_data    <= r_shift;
      r_valid   <= 1'b1;
      r_overrun <= r_valid && !sample_ready;
    end else begin
      r_overrun <= 1'b0;
      if (r_valid && sample_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_ADC_READER_OVERRUN_COUNT_EN
  logic [15:0] r_ovr_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ovr_cnt <= 16'h0000;
    end else if (overrun_clear) begin
      r_ovr_cnt <= 16'h0000;
    end else if (r_overrun && (r_ovr_cnt != 16'hFFFF)) begin
      r_ovr_cnt <= r_ovr_cnt + 16'h0001;
    end
  end

  assign overrun_count = r_ovr_cnt;
`endif

  assign spi_clock      = r_sclk;
  assign spi_chipselect = r_cs;
  assign sample_data    = r_data;
  assign sample_valid   = r_valid;
  assign overrun        = r_overrun;
  assign busy           = ~r_cs;

endmodule

`default_nettype wire

// File: tb/tb_spi_adc_reader.sv
// ============================================================================
//  Module   : tb_spi_adc_reader
//  Purpose  : Scoreboard bench for spi_adc_reader (default and HP=1/12-bit).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_adc_reader;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        enable1 = 1'b0, enable2 = 1'b0;
  logic        ready1 = 1'b1, ready2 = 1'b1;
  logic        sclk1, cs1, sclk2, cs2;
  logic        sdata1 = 1'b0, sdata2 = 1'b0;
  logic [15:0] data1;
  logic [11:0] data2;
  logic        valid1, valid2, ovr1, ovr2, busy1, busy2;
`ifdef SPI_ADC_READER_OVERRUN_COUNT_EN
  logic [15:0] ocnt1, ocnt2;
  logic        oclr1 = 1'b0, oclr2 = 1'b0;
`endif

  always #5 clock = ~clock;

  spi_adc_reader dut1 (
    .clock(clock), .resetn(resetn), .enable(enable1),
    .spi_clock(sclk1), .spi_chipselect(cs1), .spi_data(sdata1),
    .sample_data(data1), .sample_valid(valid1), .sample_ready(ready1),
    .overrun(ovr1),
`ifdef SPI_ADC_READER_OVERRUN_COUNT_EN
    .overrun_count(ocnt1), .overrun_clear(oclr1),
`endif
    .busy(busy1)
  );

  spi_adc_reader #(.SAMPLE_WIDTH(12), .HALF_PERIOD(1), .CS_HIGH_CYCLES(4)) dut2 (
    .clock(clock), .resetn(resetn), .enable(enable2),
    .spi_clock(sclk2), .spi_chipselect(cs2), .spi_data(sdata2),
    .sample_data(data2), .sample_valid(valid2), .sample_ready(ready2),
    .overrun(ovr2),
`ifdef SPI_ADC_READER_OVERRUN_COUNT_EN
    .overrun_count(ocnt2), .overrun_clear(oclr2),
`endif
    .busy(busy2)
  );

  int n_cmp = 0, n_bad = 0;
  logic [15:0] tx1[$], exp1[$];
  logic [11:0] tx2[$], exp2[$];
  logic [15:0] sreg1 = '0;
  logic [11:0] sreg2 = '0;
  int cyc = 0, falls1[$];
  int viol = 0, ovr_pulses = 0;
  int low1 = 0, rise1 = 0, low2 = 0, rise2 = 0;
  logic pcs1 = 1'b1, psclk1 = 1'b1, pcs2 = 1'b1, psclk2 = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL timeout %s: got no event, required one", name);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ADC slave models: next word is taken at chip-select fall, bits change on falling spi_clock.
  always @(negedge cs1) if (tx1.size() > 0) sreg1 = tx1.pop_front(); else sreg1 = '0;
  always @(negedge sclk1) if (!cs1) begin sdata1 = sreg1[15]; sreg1 = sreg1 << 1; end
  always @(negedge cs2) if (tx2.size() > 0) sreg2 = tx2.pop_front(); else sreg2 = '0;
  always @(negedge sclk2) if (!cs2) begin sdata2 = sreg2[11]; sreg2 = sreg2 << 1; end

  // Monitor / scoreboard for both instances.
  always @(negedge clock) begin
    cyc++;
    if (!resetn) begin
      pcs1 = 1'b1; psclk1 = 1'b1; low1 = 0; rise1 = 0;
      pcs2 = 1'b1; psclk2 = 1'b1; low2 = 0; rise2 = 0;
    end else begin
      if ((cs1 !== ~busy1) || (cs1 && !sclk1)) viol++;
      if ((cs2 !== ~busy2) || (cs2 && !sclk2)) viol++;
      if (ovr1) ovr_pulses++;
      if (ovr2) viol++;
      if (!cs1) begin
        low1++;
        if (sclk1 && !psclk1) rise1++;
        if (pcs1) falls1.push_back(cyc);
      end else if (!pcs1) begin
        check("cs_low_len", low1, 66);
        check("sclk_rises", rise1, 16);
        low1 = 0; rise1 = 0;
      end
      if (!cs2) begin
        low2++;
        if (sclk2 && !psclk2) rise2++;
      end else if (!pcs2) begin
        check("cs_low_len_w12", low2, 25);
        check("sclk_rises_w12", rise2, 12);
        low2 = 0; rise2 = 0;
      end
      if (valid1 && ready1) begin
        if (exp1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL word: got unexpected %h, required none", data1);
        end else check("word", data1, exp1.pop_front());
      end
      if (valid2 && ready2) begin
        if (exp2.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL word_w12: got unexpected %h, required none", data2);
        end else check("word_w12", data2, exp2.pop_front());
      end
      pcs1 = cs1; psclk1 = sclk1; pcs2 = cs2; psclk2 = sclk2;
    end
  end

  task automatic wait_cs_fall(input bit sel, input string name);
    bit seen_high;
    seen_high = sel ? cs2 : cs1;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (sel ? cs2 : cs1) seen_high = 1'b1;
      else if (seen_high) return;
    end
    timeout(name);
  endtask

  task automatic wait_cs_rise(input bit sel, input string name);
    for (int k = 0; k < 400; k++) begin
      tick();
      if (sel ? cs2 : cs1) return;
    end
    timeout(name);
  endtask

  task automatic wait_sclk_rises(input int n, input string name);
    logic prev;
    int cnt;
    prev = sclk1;
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (sclk1 && !prev) cnt++;
      prev = sclk1;
      if (cnt == n) return;
    end
    timeout(name);
  endtask

  task automatic push1(input logic [15:0] w, input bit expect_it);
    tx1.push_back(w);
    if (expect_it) exp1.push_back(w);
  endtask

  initial begin
    int nf, base_ovr, k;
    #2 resetn = 1'b0;
    tick(); tick(); tick();
    check("rst_cs", cs1, 1'b1);
    check("rst_sclk", sclk1, 1'b1);
    check("rst_data", data1, 16'h0000);
    check("rst_valid", valid1, 1'b0);
    check("rst_overrun", ovr1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    @(negedge clock);
    resetn = 1'b1;
    tick();

    // Single word, then back-to-back patterns.
    push1(16'hA5C3, 1); push1(16'h0000, 1); push1(16'hFFFF, 1); push1(16'h8001, 1);
    enable1 = 1'b1;
    for (int i = 0; i < 4; i++) wait_cs_fall(0, "b2b_frame");
    enable1 = 1'b0;
    wait_cs_rise(0, "b2b_end");
    repeat (10) tick();
    check("b2b_drained", exp1.size(), 0);
    if (falls1.size() >= 4) begin
      check("frame_period_1", falls1[1] - falls1[0], 71);
      check("frame_period_3", falls1[3] - falls1[2], 71);
    end else timeout("frame_count");

    // Overrun: two frames with no consumer.
    ready1 = 1'b0;
    base_ovr = ovr_pulses;
    push1(16'h1234, 0); push1(16'h5678, 1);
    enable1 = 1'b1;
    wait_cs_fall(0, "ovr_frame1");
    wait_cs_fall(0, "ovr_frame2");
    enable1 = 1'b0;
    wait_cs_rise(0, "ovr_end");
    repeat (3) tick();
    check("ovr_pulses", ovr_pulses - base_ovr, 1);
    check("ovr_data", data1, 16'h5678);
    check("ovr_valid", valid1, 1'b1);
`ifdef SPI_ADC_READER_OVERRUN_COUNT_EN
    check("ovr_count", ocnt1, 16'h0001);
    oclr1 = 1'b1; tick(); oclr1 = 1'b0;
    check("ovr_count_clr", ocnt1, 16'h0000);
`endif
    ready1 = 1'b1;
    repeat (3) tick();
    check("ovr_drained", exp1.size(), 0);

    // Drop enable at bit 5: frame completes, then stays idle.
    push1(16'h0F0F, 1);
    enable1 = 1'b1;
    wait_cs_fall(0, "dis_frame");
    wait_sclk_rises(5, "dis_bit5");
    enable1 = 1'b0;
    wait_cs_rise(0, "dis_end");
    nf = falls1.size();
    repeat (150) tick();
    check("dis_no_new_frame", falls1.size(), nf);
    check("dis_drained", exp1.size(), 0);

    // Re-enable: chip select falls CS_HIGH_CYCLES clocks later.
    push1(16'h3C3C, 1); push1(16'h1111, 0); push1(16'h2222, 0);
    enable1 = 1'b1;
    k = 0;
    do begin tick(); k++; end while (cs1 && k < 50);
    check("reenable_latency", k, 4);

    // Hold 1111 unconsumed, then reset in the middle of the 2222 frame.
    wait_cs_fall(0, "rst_frame_a");
    ready1 = 1'b0;
    wait_cs_fall(0, "rst_frame_b");
    wait_sclk_rises(8, "rst_bit8");
    check("pre_rst_valid", valid1, 1'b1);
    resetn = 1'b0;
    #1;
    check("midrst_cs", cs1, 1'b1);
    check("midrst_sclk", sclk1, 1'b1);
    check("midrst_valid", valid1, 1'b0);
    check("midrst_busy", busy1, 1'b0);
    tick(); tick();
    ready1 = 1'b1;
    push1(16'h6B9D, 1);
    @(negedge clock);
    resetn = 1'b1;
    wait_cs_fall(0, "post_rst_frame");
    enable1 = 1'b0;
    wait_cs_rise(0, "post_rst_end");
    repeat (5) tick();
    check("post_rst_drained", exp1.size(), 0);

    // Short half-period, 12-bit word.
    tx2.push_back(12'hABC); exp2.push_back(12'hABC);
    enable2 = 1'b1;
    wait_cs_fall(1, "w12_frame");
    enable2 = 1'b0;
    wait_cs_rise(1, "w12_end");
    repeat (5) tick();
    check("w12_drained", exp2.size(), 0);
    check("w12_data", data2, 12'hABC);

    check("protocol_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_adc_reader.md
Name: spi_adc_reader

Overview:
- SPI master that reads one SAMPLE_WIDTH-bit word per frame from the microphone ADC and presents it on a valid/ready stream to the clap-detection datapath.
- Generates spi_chipselect and spi_clock, and samples spi_data MSB-first.
- The slave drives each bit after a falling spi_clock; this block samples on the following rising spi_clock.
- Conversions run back-to-back while enable is high.

Parameters:
SAMPLE_WIDTH, 16, bits per frame and width of sample_data
HALF_PERIOD, 2, system clocks per spi_clock half-period (>=1)
CS_HIGH_CYCLES, 4, system clocks spi_chipselect stays high between frames (>=1)

Ports:
clock  input  1  system clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
enable  input  1  when high, frames are started continuously
spi_clock  output  1  SPI clock, idles high
spi_chipselect  output  1  active-low chip select
spi_data  input  1  serial data from ADC
sample_data  output  SAMPLE_WIDTH  last completed word
sample_valid  output  1  word available
sample_ready  input  1  consumer accepts word
overrun  output  1  one-cycle pulse: unconsumed word overwritten
busy  output  1  high while spi_chipselect is low

Behaviour:
- Reset (async assert, sync release): spi_clock=1, spi_chipselect=1, sample_data=0, sample_valid=0, overrun=0, busy=0, state=IDLE, all counters 0.
- States and transitions:
  - IDLE: chipselect high; counter runs. After CS_HIGH_CYCLES clocks in IDLE with enable=1, go to SETUP.
  - SETUP: chipselect low, spi_clock high, for HALF_PERIOD clocks, then go to LOW.
  - LOW: spi_clock low for HALF_PERIOD clocks, then go to HIGH.
  - HIGH: spi_clock high for HALF_PERIOD clocks. On the clock that enters HIGH, shift spi_data into the shift-register LSB (MSB arrives first). After SAMPLE_WIDTH HIGH phases go to DONE; otherwise return to LOW.
  - DONE: one clock. chipselect goes high, sample_data is loaded from the shift register, sample_valid is set, then go to IDLE.
- Frame timing:
  - chipselect is low for HALF_PERIOD*(1+2*SAMPLE_WIDTH) clocks.
  - Frame period is that plus 1 (DONE) plus CS_HIGH_CYCLES.
  - Defaults: 66 + 1 + 4 = 71 clocks.
- Each frame has exactly SAMPLE_WIDTH falling and SAMPLE_WIDTH rising spi_clock edges. The first falling edge follows chipselect low by HALF_PERIOD clocks.
- All SPI outputs are registered, with no glitches.
- enable:
  - Sampled only in IDLE.
  - Dropping enable mid-frame does not abort the frame; the frame completes and the block then stays in IDLE.
- Handshake:
  - A transfer occurs when sample_valid && sample_ready; sample_valid clears on the next clock unless DONE loads a new word in that same cycle, in which case sample_valid stays 1 with the new data.
  - If DONE occurs while sample_valid=1 and sample_ready=0, the new word overwrites sample_data, sample_valid stays 1, and overrun pulses for one clock.
  - sample_data is stable while sample_valid=1 and no DONE occurs.
- Reset mid-frame: outputs return to reset values immediately; the partial word is discarded.

Optional Feature:
- Macro: SPI_ADC_READER_OVERRUN_COUNT_EN.
- Defined: adds output overrun_count (16 bits), reset 0. It increments on each overrun pulse, saturates at 16'hFFFF, and is cleared by input overrun_clear (1 bit, synchronous, wins over a simultaneous increment).
- Undefined: neither port exists; overrun pulse only.

Test Plan:
- Defaults, enable=1, sample_ready=1, slave model drives 16'hA5C3 MSB-first on falling spi_clock -> sample_data=16'hA5C3, sample_valid high 1 clock. chipselect low exactly 66 clocks; 16 rising edges per frame; frame period 71 clocks.
- Back-to-back words 16'h0000, 16'hFFFF, 16'h8001 -> received in order with no bit slip; spi_clock high whenever chipselect is high.
- sample_ready=0 across two frames (16'h1234 then 16'h5678) -> overrun pulses once at the second DONE, sample_data=16'h5678; with the macro, overrun_count=1, then 0 after overrun_clear.
- enable deasserted at bit 5 of a frame -> frame completes with the correct word, then chipselect stays high indefinitely; re-enable -> next frame starts CS_HIGH_CYCLES clocks later.
- resetn pulsed low at bit 8 -> chipselect=1, spi_clock=1, sample_valid=0 in the same cycle; the next full frame returns the correct word.
- HALF_PERIOD=1, SAMPLE_WIDTH=12, word 12'hABC -> sample_data=12'hABC, chipselect low 25 clocks.
